llc_bus_responder: RTL

- Models the shared system bus and peer caches as seen from the last-level cache.
- Accepts one bus operation at a time from the LLC: READ, WRITE, INVALIDATE or RWIM.
- Returns the snoop result that the peer caches would drive, then sequences the data phase (memory fill, peer flush, or LLC writeback) and signals completion.
- This block is the bus-side counterpart the cache's MESI FSM issues BusRd/BusRdX/BusUpgr/Flush to; it also counts transactions for the trace summary.

---
 rtl/llc_bus_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/llc_bus_responder.sv
// -----------------------------------------------------------------------------
// llc_bus_responder
// Bus-side model of the shared system bus and peer caches as seen by the LLC.
// Accepts one operation at a time, returns the peer snoop result, sequences the
// data phase (DRAM fill, peer flush or LLC writeback) and pulses done. It also
// keeps saturating transaction and HITM counters for the trace summary.
//
// Ports
//   clk, rstb                  clock, asynchronous active-low reset
//   bus_req_valid/ready        operation handshake (ready only in IDLE)
//   bus_op, bus_addr           0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM; line address
//   snoop_valid/result         one-cycle snoop strobe; 0 HIT, 1 HITM, 2 NOHIT
//   beat_valid/idx/from_peer   data-phase beats and their source
//   done                       one-cycle completion pulse
//   txn_cnt, hitm_cnt          saturating statistics
// -----------------------------------------------------------------------------
module llc_bus_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_BEATS = 8,
    parameter int unsigned BEAT_W     = 3,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              bus_req_valid,
    output logic              bus_req_ready,
    input  logic [1:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              snoop_valid,
    output logic [1:0]        snoop_result,
    output logic              beat_valid,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              beat_from_peer,
    output logic              done,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic [CNT_W-1:0]  hitm_cnt
);

    localparam int unsigned LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [1:0] OP_RWIM  = 2'd3;

    localparam logic [1:0] SNP_HIT   = 2'd0;
    localparam logic [1:0] SNP_HITM  = 2'd1;
    localparam logic [1:0] SNP_NOHIT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_MEM_WAIT,
        S_XFER,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [BEAT_W-1:0]   beat_idx_q, beat_idx_d;
    logic                beat_valid_q, beat_valid_d;
    logic                beat_from_peer_q, beat_from_peer_d;
    logic                snoop_valid_q, snoop_valid_d;
    logic [1:0]          snoop_result_q, snoop_result_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    txn_cnt_q, txn_cnt_d;
    logic [CNT_W-1:0]    hitm_cnt_q, hitm_cnt_d;
    logic [1:0]          snoop_new;
    logic                op_is_read_q;

    // Peers answer only reads; the line-address LSBs pick the modelled peer state.
    function automatic logic [1:0] snoop_decode(input logic [1:0] op, input logic [1:0] lsb);
        logic [1:0] res;
        res = SNP_NOHIT;
        if (op == OP_READ || op == OP_RWIM) begin
            if (lsb == 2'b00) begin
                res = SNP_HIT;
            end else if (lsb == 2'b01) begin
                res = SNP_HITM;
            end
        end
        return res;
    endfunction

    assign snoop_new     = snoop_decode(bus_op, bus_addr[1:0]);
    assign op_is_read_q  = (op_q == OP_READ) || (op_q == OP_RWIM);
    assign bus_req_ready = (state_q == S_IDLE) && rstb;

    // Upper captured address bits are kept for visibility only.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr_q[ADDR_W-1:2];

    // Next-state and registered-output decode; outputs are aligned with state.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        addr_d           = addr_q;
        lat_d            = lat_q;
        beat_idx_d       = beat_idx_q;
        beat_from_peer_d = beat_from_peer_q;
        snoop_result_d   = snoop_result_q;
        txn_cnt_d        = txn_cnt_q;
        hitm_cnt_d       = hitm_cnt_q;
        snoop_valid_d    = 1'b0;
        beat_valid_d     = 1'b0;
        done_d           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus_req_valid) begin
                    state_d        = S_SNOOP;
                    op_d           = bus_op;
                    addr_d         = bus_addr;
                    snoop_valid_d  = 1'b1;
                    snoop_result_d = snoop_new;
                    if (txn_cnt_q != {CNT_W{1'b1}}) begin
                        txn_cnt_d = txn_cnt_q + CNT_W'(1);
                    end
                    if (snoop_new == SNP_HITM && hitm_cnt_q != {CNT_W{1'b1}}) begin
                        hitm_cnt_d = hitm_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SNOOP: begin
                if (op_is_read_q && snoop_result_q == SNP_HITM) begin
                    state_d          = S_XFER;
                    beat_from_peer_d = 1'b1;
                    beat_valid_d     = 1'b1;
                    beat_idx_d       = '0;
                end else if (op_is_read_q) begin
                    state_d = S_MEM_WAIT;
                    lat_d   = LAT_W'(MEM_LAT);
                end else if (op_q == OP_WRITE) begin
                    state_d          = S_XFER;
                    beat_from_peer_d = 1'b0;
                    beat_valid_d     = 1'b1;
                    beat_idx_d       = '0;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // lat_q counts MEM_LAT..1, so the wait lasts exactly MEM_LAT cycles.
                if (lat_q == LAT_W'(1)) begin
                    state_d          = S_XFER;
                    beat_from_peer_d = 1'b0;
                    beat_valid_d     = 1'b1;
                    beat_idx_d       = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_XFER: begin
                if (beat_idx_q == BEAT_W'(DATA_BEATS - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    beat_valid_d = 1'b1;
                    beat_idx_d   = beat_idx_q + BEAT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q          <= S_IDLE;
            op_q             <= OP_READ;
            addr_q           <= '0;
            lat_q            <= '0;
            beat_idx_q       <= '0;
            beat_valid_q     <= 1'b0;
            beat_from_peer_q <= 1'b0;
            snoop_valid_q    <= 1'b0;
            snoop_result_q   <= 2'd0;
            done_q           <= 1'b0;
            txn_cnt_q        <= '0;
            hitm_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            addr_q           <= addr_d;
            lat_q            <= lat_d;
            beat_idx_q       <= beat_idx_d;
            beat_valid_q     <= beat_valid_d;
            beat_from_peer_q <= beat_from_peer_d;
            snoop_valid_q    <= snoop_valid_d;
            snoop_result_q   <= snoop_result_d;
            done_q           <= done_d;
            txn_cnt_q        <= txn_cnt_d;
            hitm_cnt_q       <= hitm_cnt_d;
        end
    end

    assign snoop_valid    = snoop_valid_q;
    assign snoop_result   = snoop_result_q;
    assign beat_valid     = beat_valid_q;
    assign beat_idx       = beat_idx_q;
    assign beat_from_peer = beat_from_peer_q;
    assign done           = done_q;
    assign txn_cnt        = txn_cnt_q;
    assign hitm_cnt       = hitm_cnt_q;

endmodule
